// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the 5-stage 32-bit pipeline.
// Holds the PC register, a single-outstanding instruction-memory request FSM,
// a one-entry hold buffer for responses that arrive while decode is stalled,
// and the IF/ID pipeline register.
// Optional build macro: IF_FETCH_PERF_CNT_EN adds the perf_stall_cycles and
// perf_killed_fetches counters and their output ports.
//
// Handshake: a fetch request is transferred on a rising edge where both
// imem_req_valid and imem_req_ready are high; imem_req_addr is stable while
// imem_req_valid is high. The memory answers with exactly one imem_rsp_valid
// pulse per accepted request; there is no ready on the response side, and
// responses are only looked at while a request is outstanding (S_WAIT).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcWrite,
    input  logic        ifid_writeReg,
    input  logic        ifid_flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pcPlus4,
    output logic        IF_ID_valid,
    output logic [4:0]  IF_ID_regRs,
    output logic [4:0]  IF_ID_regRt,
    output logic [1:0]  fetchState
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_killed_fetches
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  fetchPc;
    logic [31:0]  fetchPcPlus4;
    logic [31:0]  redirTarget;
    logic [31:0]  holdBuf;
    logic         kill;
    logic         deliverOk;
    logic         deliver;
    logic         dropRsp;
    logic [31:0]  deliverInstr;
    logic         unusedRedirBits;

    // The low two bits of a redirect target are forced to zero.
    assign redirTarget     = {redirect_pc[31:2], 2'b00};
    assign unusedRedirBits = ^redirect_pc[1:0];
    assign fetchPcPlus4    = fetchPc + 32'd4;
    assign deliverOk       = pcWrite & ifid_writeReg & ~redirect_valid;

    // Decide whether this cycle hands an instruction to decode or drops a response.
    always_comb begin
        deliver      = 1'b0;
        dropRsp      = 1'b0;
        deliverInstr = holdBuf;
        case (state)
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill || redirect_valid) begin
                        dropRsp = 1'b1;
                    end else if (deliverOk) begin
                        deliver      = 1'b1;
                        deliverInstr = imem_rsp_data;
                    end
                end
            end
            S_HOLD: begin
                if (!redirect_valid && deliverOk) begin
                    deliver = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Request FSM: issue, wait for the single outstanding response, or park it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_REQ;
            kill    <= 1'b0;
            fetchPc <= RESET_PC;
            holdBuf <= 32'd0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        fetchPc <= pc;
                        state   <= S_WAIT;
                        // The request in flight is for the old PC; mark it stale.
                        if (redirect_valid) begin
                            kill <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (dropRsp) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else if (deliver) begin
                            state <= S_REQ;
                        end else begin
                            holdBuf <= imem_rsp_data;
                            state   <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || deliver) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // PC: a redirect always wins; otherwise advance past a delivered fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirTarget;
        end else if (deliver) begin
            pc <= fetchPcPlus4;
        end
    end

    // IF/ID register: flush, then delivery, then bubble, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            IF_ID_instr   <= NOP_INSTR;
            IF_ID_pcPlus4 <= 32'd0;
            IF_ID_valid   <= 1'b0;
        end else if (ifid_flush) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (deliver) begin
            IF_ID_instr   <= deliverInstr;
            IF_ID_pcPlus4 <= fetchPcPlus4;
            IF_ID_valid   <= 1'b1;
        end else if (ifid_writeReg) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    // Count cycles where a fetched instruction waits on decode, and dropped responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles   <= 32'd0;
            perf_killed_fetches <= 32'd0;
        end else begin
            if ((state == S_HOLD) ||
                ((state == S_WAIT) && imem_rsp_valid && !deliverOk && !kill)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (dropRsp) begin
                perf_killed_fetches <= perf_killed_fetches + 32'd1;
            end
        end
    end
`endif

    // No request may be presented while reset is held.
    assign imem_req_valid = (state == S_REQ) && !reset;
    assign imem_req_addr  = pc;
    assign IF_ID_regRs    = IF_ID_instr[25:21];
    assign IF_ID_regRt    = IF_ID_instr[20:16];
    assign fetchState     = state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed vector table, hand-written reset corner case,
// and a randomized run against a behavioural fetch model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        pcWrite, ifid_writeReg, ifid_flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic [31:0] IF_ID_instr, IF_ID_pcPlus4;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_regRs, IF_ID_regRt;
    logic [1:0]  fetchState;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_killed_fetches;
`endif

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .pcWrite        (pcWrite),
        .ifid_writeReg  (ifid_writeReg),
        .ifid_flush     (ifid_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_pcPlus4  (IF_ID_pcPlus4),
        .IF_ID_valid    (IF_ID_valid),
        .IF_ID_regRs    (IF_ID_regRs),
        .IF_ID_regRt    (IF_ID_regRt),
        .fetchState     (fetchState)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles   (perf_stall_cycles),
        .perf_killed_fetches (perf_killed_fetches)
`endif
    );

    // ---------------- bookkeeping ----------------
    int checkCount = 0;
    int passCount  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic checkIfId(input string tag, input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        logic [31:0] instrVar;
        instrVar = ei;
        check({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, ev});
        check({tag, ".instr"}, IF_ID_instr, ei);
        check({tag, ".pcPlus4"}, IF_ID_pcPlus4, ep);
        check({tag, ".rs"}, {27'd0, IF_ID_regRs}, {27'd0, instrVar[25:21]});
        check({tag, ".rt"}, {27'd0, IF_ID_regRt}, {27'd0, instrVar[20:16]});
    endtask

    // ---------------- driver tasks ----------------
    typedef struct {
        logic        pcW, wr, flush, redir;
        logic [31:0] redirPc;
        logic        ready, rspV;
        logic [31:0] rspD;
        logic        eReqV;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInstr, ePc4;
    } vec_t;

    task automatic driveIn(input logic pcW, input logic wr, input logic fl, input logic rd,
                           input logic [31:0] rdPc, input logic rdy, input logic rv,
                           input logic [31:0] rdat);
        pcWrite        = pcW;
        ifid_writeReg  = wr;
        ifid_flush     = fl;
        redirect_valid = rd;
        redirect_pc    = rdPc;
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rdat;
    endtask

    task automatic idle();
        driveIn(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic pcW, input logic wr, input logic fl, input logic rd,
                                input logic [31:0] rdPc, input logic rdy, input logic rv,
                                input logic [31:0] rdat, input logic eReqV, input logic [31:0] eAddr,
                                input logic eValid, input logic [31:0] eInstr, input logic [31:0] ePc4);
        vec_t v;
        v.pcW = pcW; v.wr = wr; v.flush = fl; v.redir = rd; v.redirPc = rdPc;
        v.ready = rdy; v.rspV = rv; v.rspD = rdat;
        v.eReqV = eReqV; v.eAddr = eAddr; v.eValid = eValid; v.eInstr = eInstr; v.ePc4 = ePc4;
        return v;
    endfunction

    // ---------------- behavioural model for the random run ----------------
    // Fetch is described in terms of "a request is outstanding", "an instruction
    // is parked", and "the outstanding fetch is doomed by an earlier redirect".
    logic [31:0] mPc, mFetch, mHeldInstr, eInstr, ePc4;
    logic        mPending, mHeld, mDoomed, eValid;
    logic [97:0] exp_q[$];

    function automatic logic [31:0] instrAt(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic modelReset();
        mPc = 32'd0; mFetch = 32'd0; mHeldInstr = 32'd0;
        mPending = 1'b0; mHeld = 1'b0; mDoomed = 1'b0;
        eInstr = NOP; ePc4 = 32'd0; eValid = 1'b0;
    endtask

    task automatic modelStep(input logic pcW, input logic wr, input logic fl, input logic rd,
                             input logic [31:0] rdPc, input logic rdy, input logic rv);
        logic        ok, got;
        logic [31:0] gotInstr, gotPc4;
        ok = pcW && wr && !rd;
        got = 1'b0;
        gotInstr = 32'd0;
        gotPc4 = mFetch + 32'd4;
        if (mPending) begin
            if (rv) begin
                mPending = 1'b0;
                if (mDoomed || rd) begin
                    mDoomed = 1'b0;
                end else if (ok) begin
                    got = 1'b1;
                    gotInstr = instrAt(mFetch);
                end else begin
                    mHeld = 1'b1;
                    mHeldInstr = instrAt(mFetch);
                end
            end else if (rd) begin
                mDoomed = 1'b1;
            end
        end else if (mHeld) begin
            if (rd) begin
                mHeld = 1'b0;
            end else if (ok) begin
                mHeld = 1'b0;
                got = 1'b1;
                gotInstr = mHeldInstr;
            end
        end else if (rdy) begin
            mPending = 1'b1;
            mFetch = mPc;
            mDoomed = rd;
        end
        if (rd) mPc = {rdPc[31:2], 2'b00};
        else if (got) mPc = gotPc4;
        if (fl) begin
            eInstr = NOP; eValid = 1'b0;
        end else if (got) begin
            eInstr = gotInstr; ePc4 = gotPc4; eValid = 1'b1;
        end else if (wr) begin
            eInstr = NOP; eValid = 1'b0;
        end
        exp_q.push_back({!mPending && !mHeld, mPc, eValid, eInstr, ePc4});
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[22];

    initial begin
        logic [97:0] rec;
        logic        memBusy, rspNow, rdy, acc;
        logic [31:0] memAddr;
        int          memDelay;

        // Directed table: inputs for one cycle, expected outputs after the edge.
        //          pcW wr  fl  rd  rdPc           rdy rv  rspD            reqV addr          v   instr          pc4
        vecs[0]  = mk(1, 1, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h0,         0, NOP,          32'h0);
        vecs[1]  = mk(1, 1, 0, 0, 32'h0,         0, 1, 32'h2002_0005,  1, 32'h4,         1, 32'h2002_0005, 32'h4);
        vecs[2]  = mk(1, 1, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h4,         0, NOP,          32'h4);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h8C43_0008,  0, 32'h4,         0, NOP,          32'h4);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h4,         0, NOP,          32'h4);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h4,         0, NOP,          32'h4);
        vecs[6]  = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h8,         1, 32'h8C43_0008, 32'h8);
        vecs[7]  = mk(1, 1, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h8,         0, NOP,          32'h8);
        vecs[8]  = mk(1, 1, 0, 1, 32'h43,        0, 0, 32'h0,          0, 32'h40,        0, NOP,          32'h8);
        vecs[9]  = mk(1, 1, 0, 0, 32'h0,         0, 1, 32'hDEAD_BEEF,  1, 32'h40,        0, NOP,          32'h8);
        vecs[10] = mk(1, 1, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h40,        0, NOP,          32'h8);
        vecs[11] = mk(1, 1, 1, 1, 32'h100,       0, 1, 32'h1111_2222,  1, 32'h100,       0, NOP,          32'h8);
        vecs[12] = mk(1, 1, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,          0, 32'hFFFF_FFFC, 0, NOP,          32'h8);
        vecs[13] = mk(1, 1, 0, 0, 32'h0,         0, 1, 32'h3333_4444,  1, 32'hFFFF_FFFC, 0, NOP,          32'h8);
        vecs[14] = mk(1, 1, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'hFFFF_FFFC, 0, NOP,          32'h8);
        vecs[15] = mk(1, 1, 0, 0, 32'h0,         0, 1, 32'h00A4_2020,  1, 32'h0,         1, 32'h00A4_2020, 32'h0);
        vecs[16] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h0,         0, NOP,          32'h0);
        vecs[17] = mk(1, 1, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h0,         0, NOP,          32'h0);
        vecs[18] = mk(1, 1, 0, 0, 32'h0,         0, 1, 32'h0128_4820,  1, 32'h4,         1, 32'h0128_4820, 32'h4);
        vecs[19] = mk(1, 0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h4,         1, 32'h0128_4820, 32'h4);
        vecs[20] = mk(1, 0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 32'h4,         0, NOP,          32'h4);
        vecs[21] = mk(1, 1, 0, 1, 32'h202,       0, 0, 32'h0,          1, 32'h200,       0, NOP,          32'h4);

        // Reset: outputs cleared, no request while reset is high.
        reset = 1'b1;
        idle();
        tick();
        tick();
        check("rst.reqValid", {31'd0, imem_req_valid}, 32'd0);
        checkIfId("rst", 1'b0, NOP, 32'd0);
        reset = 1'b0;
        #1;
        check("rst.reqAfter", {31'd0, imem_req_valid}, 32'd1);
        check("rst.addr", imem_req_addr, 32'd0);

        for (int i = 0; i < 22; i++) begin
            driveIn(vecs[i].pcW, vecs[i].wr, vecs[i].flush, vecs[i].redir, vecs[i].redirPc,
                    vecs[i].ready, vecs[i].rspV, vecs[i].rspD);
            tick();
            check($sformatf("vec%0d.reqValid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].eReqV});
            check($sformatf("vec%0d.addr", i), imem_req_addr, vecs[i].eAddr);
            checkIfId($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eInstr, vecs[i].ePc4);
`ifdef IF_FETCH_PERF_CNT_EN
            if (i == 6)  check("perf.stall", perf_stall_cycles, 32'd4);
            if (i == 9)  check("perf.killed1", perf_killed_fetches, 32'd1);
            if (i == 13) check("perf.killed3", perf_killed_fetches, 32'd3);
`endif
        end

        // Reset while a request is outstanding and IF/ID holds a real instruction.
        driveIn(1, 1, 0, 0, 32'h0, 1, 0, 32'h0);            tick();   // accept 0x200
        driveIn(1, 1, 0, 0, 32'h0, 0, 1, 32'h2108_FFFF);    tick();   // deliver
        checkIfId("mid.deliver", 1'b1, 32'h2108_FFFF, 32'h204);
        driveIn(1, 0, 0, 0, 32'h0, 1, 0, 32'h0);            tick();   // accept 0x204, IF/ID held
        checkIfId("mid.held", 1'b1, 32'h2108_FFFF, 32'h204);
        reset = 1'b1;
        idle();
        tick();
        check("mid.rstReqValid", {31'd0, imem_req_valid}, 32'd0);
        checkIfId("mid.rst", 1'b0, NOP, 32'd0);
        reset = 1'b0;
        driveIn(1, 1, 0, 0, 32'h0, 0, 1, 32'hCAFE_F00D);    tick();   // stale response
        check("mid.staleReqValid", {31'd0, imem_req_valid}, 32'd1);
        check("mid.staleAddr", imem_req_addr, 32'd0);
        checkIfId("mid.stale", 1'b0, NOP, 32'd0);

        // Randomized run against the model with a variable-latency memory.
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        modelReset();
        memBusy = 1'b0;
        memAddr = 32'd0;
        memDelay = 0;
        for (int c = 0; c < 3000; c++) begin
            logic pcW, wr, fl, rd;
            logic [31:0] rdPc;
            rspNow = memBusy && (memDelay == 0);
            rdy  = ($urandom_range(0, 9) < 6);
            pcW  = ($urandom_range(0, 9) < 8);
            wr   = ($urandom_range(0, 9) < 8);
            fl   = ($urandom_range(0, 9) == 0);
            rd   = ($urandom_range(0, 9) == 0);
            rdPc = $urandom;
            if ($urandom_range(0, 7) == 0) rdPc = 32'hFFFF_FFFC;
            driveIn(pcW, wr, fl, rd, rdPc, rdy, rspNow, instrAt(memAddr));
            modelStep(pcW, wr, fl, rd, rdPc, rdy, rspNow);
            acc = imem_req_valid && rdy;
            if (rspNow) memBusy = 1'b0;
            else if (memBusy) memDelay--;
            if (acc) begin
                memBusy  = 1'b1;
                memAddr  = imem_req_addr;
                memDelay = $urandom_range(0, 2);
            end
            tick();
            rec = exp_q.pop_front();
            check("rnd.reqValid", {31'd0, imem_req_valid}, {31'd0, rec[97]});
            check("rnd.addr", imem_req_addr, rec[96:65]);
            check("rnd.valid", {31'd0, IF_ID_valid}, {31'd0, rec[64]});
            check("rnd.instr", IF_ID_instr, rec[63:32]);
            check("rnd.pcPlus4", IF_ID_pcPlus4, rec[31:0]);
        end

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage 32-bit pipeline: PC register, single-outstanding instruction-memory request FSM, one-entry hold buffer, and the IF/ID pipeline register.
- Consumes pcWrite / ifid_writeReg from the load-use hazard detector.
- Consumes redirect and flush from the branch/jump logic.
- Produces the IF/ID fields, including IF_ID_regRs and IF_ID_regRt, which feed the hazard detector.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID for a bubble.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- pcWrite  input  1  from hazard detector; 0 = PC stall
- ifid_writeReg  input  1  from hazard detector; 0 = IF/ID hold
- ifid_flush  input  1  load bubble into IF/ID this cycle
- redirect_valid  input  1  taken branch/jump this cycle
- redirect_pc  input  32  target PC; bits [1:0] ignored, treated as 00
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  32  fetch address
- imem_req_ready  input  1  memory accepts request
- imem_rsp_valid  input  1  instruction return valid
- imem_rsp_data  input  32  returned instruction
- IF_ID_instr  output  32  latched instruction
- IF_ID_pcPlus4  output  32  latched fetch PC + 4
- IF_ID_valid  output  1  1 = real instruction, 0 = bubble
- IF_ID_regRs  output  5  IF_ID_instr[25:21], combinational
- IF_ID_regRt  output  5  IF_ID_instr[20:16], combinational

Behaviour:
- Reset (synchronous, active-high):
  - pc = RESET_PC, state = S_REQ, kill = 0, hold buffer cleared.
  - IF_ID_instr = NOP_INSTR, IF_ID_pcPlus4 = 0, IF_ID_valid = 0.
  - imem_req_valid = 0 during any cycle reset is high.
  - Reset mid-operation aborts everything.
  - imem_rsp_valid is ignored outside S_WAIT, so stale responses are dropped.
- Deliver enable: deliver_ok = pcWrite & ifid_writeReg & ~redirect_valid.
- S_REQ:
  - imem_req_valid = 1, imem_req_addr = pc.
  - On imem_req_ready: fetch_pc <= pc, go to S_WAIT.
  - If redirect_valid is also high that cycle, set kill = 1.
- S_WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid with kill = 1 or redirect_valid: drop the response, clear kill, go to S_REQ.
  - Else if deliver_ok: write IF/ID = {rsp_data, fetch_pc+4, valid=1}, pc <= fetch_pc+4, go to S_REQ.
  - Else: store rsp_data in the hold buffer, go to S_HOLD.
  - Without rsp_valid, redirect_valid sets kill = 1.
- S_HOLD:
  - imem_req_valid = 0.
  - redirect_valid: discard the buffer, go to S_REQ.
  - Else if deliver_ok: write IF/ID from the buffer, pc <= fetch_pc+4, go to S_REQ.
- redirect_valid always loads pc <= {redirect_pc[31:2],2'b00}, overriding pcWrite and any pc+4 update.
- IF/ID register priority (highest first):
  1. ifid_flush → bubble (instr = NOP_INSTR, valid = 0, pcPlus4 unchanged).
  2. Delivery event → real instruction.
  3. ifid_writeReg = 1 with no delivery → bubble.
  4. ifid_writeReg = 0 → hold all fields.
- A delivery cancelled by flush in the same cycle is lost; branch logic pairs flush with redirect.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Throughput: with a 1-cycle memory, one instruction every 2 cycles (request, then response).
- At most one request is outstanding.

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_killed_fetches[31:0], both reset to 0 and wrapping at 2^32.
  - perf_stall_cycles increments each cycle in S_HOLD, or each cycle in S_WAIT with rsp_valid and ~deliver_ok and no kill.
  - perf_killed_fetches increments on each dropped response.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then 1-cycle memory returning 32'h2002_0005 at addr 0 → IF_ID_instr = 32'h2002_0005, IF_ID_pcPlus4 = 4, IF_ID_valid = 1, next imem_req_addr = 4.
- Response arrives with pcWrite = 0 and ifid_writeReg = 0 for 3 cycles:
  - FSM in S_HOLD, IF/ID unchanged, pc unchanged.
  - Deassert the stall → buffered instruction delivered next edge, pc = fetch_pc+4.
- redirect_valid with redirect_pc = 32'h0000_0043 while in S_WAIT → response dropped, next imem_req_addr = 32'h0000_0040, perf_killed_fetches = 1 (macro on).
- redirect_valid and ifid_flush in the same cycle as rsp_valid → IF_ID_valid = 0, IF_ID_instr = NOP_INSTR, pc = redirect target.
- pc = 32'hFFFF_FFFC fetch delivered → IF_ID_pcPlus4 = 0, next request addr = 0.
- Reset asserted in S_WAIT, rsp_valid arrives 1 cycle after reset drops → response ignored, IF_ID_valid = 0, request to RESET_PC issued.
